icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the CPU instruction port and the
//  cpu_axi_interface instruction port. Both sides use the SRAM-like req/addr_ok/data_ok protocol.
//  kseg1 fetches and all writes bypass the array. Hits return in 1 cycle; misses refill one word.
// PARAMETERS
//  INDEX_WIDTH   7       log2(number of lines); tag = addr[31:INDEX_WIDTH+2]
//  UNCACHED_SEG  3'b101  addr[31:29] value that marks an access as uncached (kseg1)
// PORTS
//  clk                 in   1   clock; all state updates on the rising edge
//  rst                 in   1   synchronous, active-high reset
//  cpu_inst_req        in   1   CPU request, held until cpu_inst_addr_ok
//  cpu_inst_wr         in   1   1 = write (uncached pass-through)
//  cpu_inst_size       in   2   0/1/2 = byte/half/word
//  cpu_inst_addr       in   32  request address
//  cpu_inst_wdata      in   32  write data
//  cpu_inst_rdata      out  32  read data, valid when cpu_inst_data_ok
//  cpu_inst_addr_ok    out  1   request accepted this cycle
//  cpu_inst_data_ok    out  1   1-cycle pulse: access complete
//  cache_inst_req      out  1   downstream request, held until cache_inst_addr_ok
//  cache_inst_wr       out  1   downstream write flag
//  cache_inst_size     out  2   downstream size
//  cache_inst_addr     out  32  downstream address
//  cache_inst_wdata    out  32  downstream write data
//  cache_inst_rdata    in   32  downstream read data
//  cache_inst_addr_ok  in   1   downstream accepted request
//  cache_inst_data_ok  in   1   downstream access complete
// BEHAVIOUR
//  Storage: valid[2^IW], tag[2^IW], data[2^IW] registers; index = addr[IW+1:2].
//  Reset: state=IDLE, all valid bits=0, req_* latches=0, every output=0.
//  States: IDLE, LOOKUP, MISS, REFILL.
//  IDLE:   cpu_inst_addr_ok = cpu_inst_req. On handshake, latch addr/wr/size/wdata -> LOOKUP.
//  LOOKUP: addr_ok=0. Latched addr is cached when addr[31:29]!=UNCACHED_SEG.
//          hit = cached & !wr & valid[idx] & tag[idx]==addr tag.
//          hit: data_ok=1, rdata=data[idx], -> IDLE.
//          otherwise: -> MISS. If wr and the line matches, clear valid[idx] now.
//  MISS:   cache_inst_req=1; addr/wr/wdata from latches; size = latched size.
//          Hold all outputs stable until cache_inst_addr_ok; on it -> REFILL, same cycle req drops.
//  REFILL: req=0; wait for cache_inst_data_ok.
//          On it: data_ok=1, rdata=cache_inst_rdata (combinational forward), -> IDLE.
//          If cached & !wr, write valid=1, tag and data for idx.
//  Latency from the addr_ok cycle:
//          hit: data_ok on the next cycle.
//          miss: 1 cycle + downstream addr_ok wait + downstream data latency.
//  One access outstanding at most; addr_ok=0 in every state except IDLE, no back-to-back accept.
//  data_ok and addr_ok never assert together; cpu_inst_rdata holds its last value when not valid.
//  Uncached reads and all writes never modify data/tag; a write only invalidates a matching line.
//  cache_inst_data_ok outside REFILL and cache_inst_addr_ok outside MISS are ignored.
//  rst mid-access (any state): return to IDLE and clear all valid bits; no data_ok is produced
//  for the abandoned access.
//  Index/tag arithmetic is pure bit slicing; addr[1:0] is ignored for cached lookups.
// TESTING
//  1 Cold miss: read 0x8000_0100 with downstream data 0x2402_0001 after 3 cycles -> one downstream req
//    at 0x8000_0100, cpu data_ok with 0x2402_0001; a repeat read hits with data_ok 1 cycle after
//    addr_ok and no downstream req.
//  2 Conflict: read 0x8000_0100, then 0x8000_0300 (same index, IW=7) -> second read misses and
//    refills; a third read of 0x8000_0100 misses again.
//  3 Uncached: read 0xBFC0_0000 twice -> two downstream reqs, array unchanged (follow-up at the same
//    index still misses).
//  4 Write invalidate: fill 0x8000_0040, write 0x1234_5678 to it -> downstream wr=1 size=2, then a
//    read misses and refetches.
//  5 Backpressure: hold cache_inst_addr_ok=0 for 5 cycles -> cache_inst_req, addr and size stable
//    throughout; cpu_inst_addr_ok stays 0.
//  6 Reset in REFILL: assert rst one cycle, then a late cache_inst_data_ok -> no cpu data_ok; the
//    next read of the same address misses.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the CPU
// instruction port and the downstream AXI bridge instruction port. Both sides
// use the SRAM-like req/addr_ok/data_ok handshake. kseg1 fetches and every
// write bypass the array; a write only invalidates a matching line.
module icache_dm #(
  parameter int unsigned INDEX_WIDTH  = 7,
  parameter logic [2:0]  UNCACHED_SEG = 3'b101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok
);

  localparam int unsigned LINES = 32'd1 << INDEX_WIDTH;
  localparam int unsigned TAG_W = 32'd32 - INDEX_WIDTH - 32'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2,
    REFILL = 2'd3
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  // Latched request (one access outstanding at most)
  logic [31:0] req_addr_r;
  logic        req_wr_r;
  logic [1:0]  req_size_r;
  logic [31:0] req_wdata_r;

  // Line storage
  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [31:0]      data_r [LINES];

  // Last word handed to the CPU, kept on the bus between completions
  logic [31:0] last_rdata_r;

  // Lookup decode of the latched address
  logic [INDEX_WIDTH-1:0] idx_s;
  logic [TAG_W-1:0]       tag_s;
  logic                   cached_s;
  logic                   match_s;
  logic                   hit_s;

  // Controller decisions
  logic        accept_s;
  logic        data_ok_s;
  logic [31:0] rdata_s;
  logic        inval_s;
  logic        fill_s;

  assign idx_s    = req_addr_r[INDEX_WIDTH+1:2];
  assign tag_s    = req_addr_r[31:INDEX_WIDTH+2];
  assign cached_s = (req_addr_r[31:29] != UNCACHED_SEG);
  assign match_s  = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign hit_s    = cached_s && !req_wr_r && match_s;

  assign cpu_inst_addr_ok = accept_s;
  assign cpu_inst_data_ok = data_ok_s;
  assign cpu_inst_rdata   = rdata_s;

  // Next-state and output decode; reset forces every output low
  always_comb begin
    state_nxt_s      = state_r;
    accept_s         = 1'b0;
    data_ok_s        = 1'b0;
    rdata_s          = last_rdata_r;
    inval_s          = 1'b0;
    fill_s           = 1'b0;
    cache_inst_req   = 1'b0;
    cache_inst_wr    = 1'b0;
    cache_inst_size  = 2'd0;
    cache_inst_addr  = 32'd0;
    cache_inst_wdata = 32'd0;
    if (rst) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          accept_s = cpu_inst_req;
          if (cpu_inst_req) begin
            state_nxt_s = LOOKUP;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            data_ok_s   = 1'b1;
            rdata_s     = data_r[idx_s];
            state_nxt_s = IDLE;
          end else begin
            // A write to a resident line kills it before going downstream
            inval_s     = req_wr_r && match_s;
            state_nxt_s = MISS;
          end
        end
        MISS: begin
          cache_inst_req   = 1'b1;
          cache_inst_wr    = req_wr_r;
          cache_inst_size  = req_size_r;
          cache_inst_addr  = req_addr_r;
          cache_inst_wdata = req_wdata_r;
          if (cache_inst_addr_ok) begin
            state_nxt_s = REFILL;
          end else begin
            state_nxt_s = MISS;
          end
        end
        REFILL: begin
          if (cache_inst_data_ok) begin
            data_ok_s   = 1'b1;
            rdata_s     = cache_inst_rdata;
            fill_s      = cached_s && !req_wr_r;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = REFILL;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State register and request latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      req_addr_r  <= 32'd0;
      req_wr_r    <= 1'b0;
      req_size_r  <= 2'd0;
      req_wdata_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        req_addr_r  <= cpu_inst_addr;
        req_wr_r    <= cpu_inst_wr;
        req_size_r  <= cpu_inst_size;
        req_wdata_r <= cpu_inst_wdata;
      end
    end
  end

  // Valid bits: cleared by reset, set on refill, cleared by a matching write
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (fill_s) begin
      valid_r[idx_s] <= 1'b1;
    end else if (inval_s) begin
      valid_r[idx_s] <= 1'b0;
    end
  end

  // Tag and data arrays; contents are meaningless while the valid bit is low
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_r[idx_s]  <= tag_s;
      data_r[idx_s] <= cache_inst_rdata;
    end
  end

  // Remember the last returned word so rdata is stable between completions
  always_ff @(posedge clk) begin
    if (rst) begin
      last_rdata_r <= 32'd0;
    end else if (data_ok_s) begin
      last_rdata_r <= rdata_s;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed, table-driven bench for icache_dm. The bench plays both the CPU
// and the downstream slave; inputs change on the falling edge and outputs are
// sampled 1 time unit later, well before the next rising edge.
module tb_icache_dm;

  logic        clk;
  logic        rst;
  logic        cpu_inst_req;
  logic        cpu_inst_wr;
  logic [1:0]  cpu_inst_size;
  logic [31:0] cpu_inst_addr;
  logic [31:0] cpu_inst_wdata;
  logic [31:0] cpu_inst_rdata;
  logic        cpu_inst_addr_ok;
  logic        cpu_inst_data_ok;
  logic        cache_inst_req;
  logic        cache_inst_wr;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr;
  logic [31:0] cache_inst_wdata;
  logic [31:0] cache_inst_rdata;
  logic        cache_inst_addr_ok;
  logic        cache_inst_data_ok;

  int checks;
  int failures;

  icache_dm dut (
    .clk                (clk),
    .rst                (rst),
    .cpu_inst_req       (cpu_inst_req),
    .cpu_inst_wr        (cpu_inst_wr),
    .cpu_inst_size      (cpu_inst_size),
    .cpu_inst_addr      (cpu_inst_addr),
    .cpu_inst_wdata     (cpu_inst_wdata),
    .cpu_inst_rdata     (cpu_inst_rdata),
    .cpu_inst_addr_ok   (cpu_inst_addr_ok),
    .cpu_inst_data_ok   (cpu_inst_data_ok),
    .cache_inst_req     (cache_inst_req),
    .cache_inst_wr      (cache_inst_wr),
    .cache_inst_size    (cache_inst_size),
    .cache_inst_addr    (cache_inst_addr),
    .cache_inst_wdata   (cache_inst_wdata),
    .cache_inst_rdata   (cache_inst_rdata),
    .cache_inst_addr_ok (cache_inst_addr_ok),
    .cache_inst_data_ok (cache_inst_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] dn_data;
    int          ao_wait;
    int          do_wait;
    logic        exp_miss;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete CPU access with the bench acting as downstream slave
  task automatic run_access(input vec_t v);
    int cyc;
    int dn_reqs;
    int ao_cnt;
    int do_cnt;
    bit granted;
    bit done;
    int exp_lat;
    logic [31:0] got;
    got = 32'd0;
    @(negedge clk);
    cpu_inst_req   = 1'b1;
    cpu_inst_wr    = v.wr;
    cpu_inst_size  = v.size;
    cpu_inst_addr  = v.addr;
    cpu_inst_wdata = v.wdata;
    #1;
    chk({v.name, " accept"}, {31'd0, cpu_inst_addr_ok}, 32'd1);
    // Keep req high so a second accept during the access would be caught
    @(negedge clk);
    cyc = 1; dn_reqs = 0; ao_cnt = 0; do_cnt = 0; granted = 1'b0; done = 1'b0;
    while (!done && cyc < 60) begin
      cache_inst_addr_ok = 1'b0;
      cache_inst_data_ok = 1'b0;
      cache_inst_rdata   = 32'hDEAD_BEEF;
      if (granted) begin
        if (do_cnt == v.do_wait) begin
          cache_inst_data_ok = 1'b1;
          cache_inst_rdata   = v.dn_data;
        end else begin
          do_cnt++;
        end
      end
      #1;
      chk({v.name, " no_accept"}, {31'd0, cpu_inst_addr_ok}, 32'd0);
      if (cache_inst_req) begin
        chk({v.name, " dn_addr"}, cache_inst_addr, v.addr);
        chk({v.name, " dn_wr"}, {31'd0, cache_inst_wr}, {31'd0, v.wr});
        chk({v.name, " dn_size"}, {30'd0, cache_inst_size}, {30'd0, v.size});
        chk({v.name, " dn_wdata"}, cache_inst_wdata, v.wdata);
        if (ao_cnt == v.ao_wait) begin
          cache_inst_addr_ok = 1'b1;
          dn_reqs++;
          granted = 1'b1;
        end else begin
          ao_cnt++;
        end
      end
      if (cpu_inst_data_ok) begin
        done = 1'b1;
        got  = cpu_inst_rdata;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    exp_lat = v.exp_miss ? (3 + v.ao_wait + v.do_wait) : 1;
    chk({v.name, " done"}, {31'd0, done}, 32'd1);
    chk({v.name, " latency"}, cyc, exp_lat);
    chk({v.name, " dn_reqs"}, dn_reqs, v.exp_miss ? 32'd1 : 32'd0);
    chk({v.name, " rdata"}, got, v.exp_rdata);
    // Idle cycle: no completion and rdata holds the returned word
    @(negedge clk);
    cpu_inst_req       = 1'b0;
    cache_inst_addr_ok = 1'b0;
    cache_inst_data_ok = 1'b0;
    cache_inst_rdata   = 32'hDEAD_BEEF;
    #1;
    chk({v.name, " idle_data_ok"}, {31'd0, cpu_inst_data_ok}, 32'd0);
    chk({v.name, " rdata_hold"}, cpu_inst_rdata, v.exp_rdata);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //          name            addr          wr    sz    wdata         dn_data       ao do miss  exp_rdata
    vecs[0]  = '{"cold_miss",    32'h8000_0100, 1'b0, 2'd2, 32'h0000_0000, 32'h2402_0001, 0, 2, 1'b1, 32'h2402_0001};
    vecs[1]  = '{"cold_hit",     32'h8000_0100, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000, 0, 0, 1'b0, 32'h2402_0001};
    vecs[2]  = '{"conf_fill",    32'h8000_0300, 1'b0, 2'd2, 32'h0000_0000, 32'h3C1D_0000, 1, 0, 1'b1, 32'h3C1D_0000};
    vecs[3]  = '{"conf_remiss",  32'h8000_0100, 1'b0, 2'd2, 32'h0000_0000, 32'h2402_0001, 0, 1, 1'b1, 32'h2402_0001};
    vecs[4]  = '{"conf_hit",     32'h8000_0100, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000, 0, 0, 1'b0, 32'h2402_0001};
    vecs[5]  = '{"unc_pre_fill", 32'h8000_0000, 1'b0, 2'd2, 32'h0000_0000, 32'h8F88_0000, 0, 0, 1'b1, 32'h8F88_0000};
    vecs[6]  = '{"unc_rd1",      32'hBFC0_0000, 1'b0, 2'd2, 32'h0000_0000, 32'h3C08_8000, 0, 0, 1'b1, 32'h3C08_8000};
    vecs[7]  = '{"unc_rd2",      32'hBFC0_0000, 1'b0, 2'd2, 32'h0000_0000, 32'h3C08_8001, 0, 3, 1'b1, 32'h3C08_8001};
    vecs[8]  = '{"unc_keep",     32'h8000_0000, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000, 0, 0, 1'b0, 32'h8F88_0000};
    vecs[9]  = '{"unc_byte",     32'hA000_0003, 1'b0, 2'd0, 32'h0000_0000, 32'h0000_00AB, 0, 0, 1'b1, 32'h0000_00AB};
    vecs[10] = '{"wr_fill",      32'h8000_0040, 1'b0, 2'd2, 32'h0000_0000, 32'h1111_1111, 0, 0, 1'b1, 32'h1111_1111};
    vecs[11] = '{"wr_prehit",    32'h8000_0040, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000, 0, 0, 1'b0, 32'h1111_1111};
    vecs[12] = '{"wr_inval",     32'h8000_0040, 1'b1, 2'd2, 32'h1234_5678, 32'h0000_0000, 0, 0, 1'b1, 32'h0000_0000};
    vecs[13] = '{"wr_refetch",   32'h8000_0040, 1'b0, 2'd2, 32'h0000_0000, 32'h2222_2222, 0, 0, 1'b1, 32'h2222_2222};
    vecs[14] = '{"low_bits",     32'h8000_0042, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000, 0, 0, 1'b0, 32'h2222_2222};
    vecs[15] = '{"unc_wr",       32'hA000_0040, 1'b1, 2'd2, 32'hCAFE_F00D, 32'h0000_0000, 0, 0, 1'b1, 32'h0000_0000};
    vecs[16] = '{"unc_wr_keep",  32'h8000_0040, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000, 0, 0, 1'b0, 32'h2222_2222};
    vecs[17] = '{"backpressure", 32'h8000_0080, 1'b0, 2'd2, 32'h0000_0000, 32'h27BD_FFF0, 5, 1, 1'b1, 32'h27BD_FFF0};
    vecs[18] = '{"bp_hit",       32'h8000_0080, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000, 0, 0, 1'b0, 32'h27BD_FFF0};
    // After the mid-refill reset
    vecs[19] = '{"rst_remiss",   32'h8000_0500, 1'b0, 2'd2, 32'h0000_0000, 32'h6666_6666, 0, 0, 1'b1, 32'h6666_6666};
    vecs[20] = '{"rst_inval0",   32'h8000_0000, 1'b0, 2'd2, 32'h0000_0000, 32'h7777_7777, 0, 0, 1'b1, 32'h7777_7777};
    vecs[21] = '{"rst_inval1",   32'h8000_0100, 1'b0, 2'd2, 32'h0000_0000, 32'h2402_0001, 0, 0, 1'b1, 32'h2402_0001};

    rst                = 1'b1;
    cpu_inst_req       = 1'b0;
    cpu_inst_wr        = 1'b0;
    cpu_inst_size      = 2'd0;
    cpu_inst_addr      = 32'd0;
    cpu_inst_wdata     = 32'd0;
    cache_inst_rdata   = 32'd0;
    cache_inst_addr_ok = 1'b0;
    cache_inst_data_ok = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset addr_ok", {31'd0, cpu_inst_addr_ok}, 32'd0);
    chk("reset data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
    chk("reset rdata", cpu_inst_rdata, 32'd0);
    chk("reset dn_req", {31'd0, cache_inst_req}, 32'd0);
    chk("reset dn_addr", cache_inst_addr, 32'd0);
    chk("reset dn_size", {30'd0, cache_inst_size}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      run_access(vecs[i]);
    end

    // Reset while waiting in REFILL, then a stale downstream data_ok
    @(negedge clk);
    cpu_inst_req   = 1'b1;
    cpu_inst_wr    = 1'b0;
    cpu_inst_size  = 2'd2;
    cpu_inst_addr  = 32'h8000_0500;
    cpu_inst_wdata = 32'd0;
    #1;
    chk("rst_seq accept", {31'd0, cpu_inst_addr_ok}, 32'd1);
    @(negedge clk);
    cpu_inst_req = 1'b0;
    #1;
    chk("rst_seq lookup_data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_seq miss_req", {31'd0, cache_inst_req}, 32'd1);
    chk("rst_seq miss_addr", cache_inst_addr, 32'h8000_0500);
    cache_inst_addr_ok = 1'b1;
    @(negedge clk);
    cache_inst_addr_ok = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_seq refill_req", {31'd0, cache_inst_req}, 32'd0);
    chk("rst_seq rst_data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
    @(negedge clk);
    rst                = 1'b0;
    cache_inst_data_ok = 1'b1;
    cache_inst_rdata   = 32'h5555_5555;
    #1;
    chk("rst_seq late_data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
    chk("rst_seq rdata_cleared", cpu_inst_rdata, 32'd0);
    // Stray downstream handshakes while idle are ignored
    @(negedge clk);
    cache_inst_data_ok = 1'b0;
    cache_inst_addr_ok = 1'b1;
    #1;
    chk("stray idle_data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
    @(negedge clk);
    cache_inst_addr_ok = 1'b0;
    #1;
    chk("stray idle_dn_req", {31'd0, cache_inst_req}, 32'd0);
    chk("stray idle_data_ok2", {31'd0, cpu_inst_data_ok}, 32'd0);

    for (int i = 19; i < NVEC; i++) begin
      run_access(vecs[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
